// File: rtl/configuration_register_bank_if.sv
// Register-write stream from the host-link RX deframer: address/data/strobe plus
// the soft-reset strobe. The deframer drives the master side, the register bank listens on the slave side.
interface configuration_register_bank_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] register_addr;
   logic [DATA_WIDTH-1:0] register_data;
   logic                  register_rdy;
   logic                  rst_seq;

   modport master (
      output register_addr,
      output register_data,
      output register_rdy,
      output rst_seq
   );

   modport slave (
      input register_addr,
      input register_data,
      input register_rdy,
      input rst_seq
   );
endinterface

// File: rtl/configuration_register_bank.sv
// Shadow/active configuration register bank with atomic, hold-deferrable commit.
// Optional byte-serial readback of active registers when CFG_READBACK_EN is defined.
module configuration_register_bank #(
   parameter int REG_ADDR_WIDTH = 8,
   parameter int REG_DATA_WIDTH = 16,
   parameter int NUM_REGS       = 8,
   parameter logic [REG_ADDR_WIDTH-1:0] COMMIT_ADDR = 8'hFF,
   parameter logic [REG_ADDR_WIDTH-1:0] RDBK_ADDR   = 8'hFE,
   parameter logic [NUM_REGS*REG_DATA_WIDTH-1:0] REG_DEFAULTS = '0
) (
   input  logic                               clk,
   input  logic                               rst,
   configuration_register_bank_if.slave       wr,
   input  logic                               hold,
   output logic [NUM_REGS*REG_DATA_WIDTH-1:0] cfg_regs,
   output logic [NUM_REGS-1:0]                update_mask,
   output logic                               commit_pending,
   output logic                               cfg_rst,
   output logic                               addr_err
`ifdef CFG_READBACK_EN
   ,
   output logic [7:0]                         tx_data,
   output logic                               tx_rdy,
   input  logic                               tx_ack
`endif
);

   logic [REG_DATA_WIDTH-1:0] shadow [NUM_REGS];
   logic [REG_DATA_WIDTH-1:0] active [NUM_REGS];
   logic [NUM_REGS-1:0]       dirty;
   logic [NUM_REGS-1:0]       reg_hit;
   logic                      commit_req;
   logic                      rdbk_req;
   logic                      rdbk_err;
   logic                      other_req;
   logic                      do_commit;

   always_comb begin
      reg_hit = '0;
      for (int i = 0; i < NUM_REGS; i++)
         reg_hit[i] = wr.register_rdy && (wr.register_addr == REG_ADDR_WIDTH'(i));
   end

   assign commit_req = wr.register_rdy && (wr.register_addr == COMMIT_ADDR);
   assign rdbk_req   = wr.register_rdy && (wr.register_addr == RDBK_ADDR);
   assign other_req  = wr.register_rdy && !(|reg_hit) && !commit_req && !rdbk_req;
   // A pending commit fires on the first edge with hold low, merging any repeats.
   assign do_commit  = (commit_req || commit_pending) && !hold;

   always_comb begin
      cfg_regs = '0;
      for (int i = 0; i < NUM_REGS; i++)
         cfg_regs[i*REG_DATA_WIDTH +: REG_DATA_WIDTH] = active[i];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            shadow[i] <= REG_DEFAULTS[i*REG_DATA_WIDTH +: REG_DATA_WIDTH];
            active[i] <= REG_DEFAULTS[i*REG_DATA_WIDTH +: REG_DATA_WIDTH];
         end
         dirty          <= '0;
         update_mask    <= '0;
         commit_pending <= 1'b0;
         cfg_rst        <= 1'b0;
         addr_err       <= 1'b0;
      end else if (wr.rst_seq) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            shadow[i] <= REG_DEFAULTS[i*REG_DATA_WIDTH +: REG_DATA_WIDTH];
            active[i] <= REG_DEFAULTS[i*REG_DATA_WIDTH +: REG_DATA_WIDTH];
         end
         dirty          <= '0;
         update_mask    <= '0;
         commit_pending <= 1'b0;
         cfg_rst        <= 1'b1;
         addr_err       <= 1'b0;
      end else begin
         cfg_rst     <= 1'b0;
         addr_err    <= other_req || rdbk_err;
         update_mask <= '0;
         if (do_commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
               active[i]      <= shadow[i];
               update_mask[i] <= dirty[i] && (shadow[i] != active[i]);
            end
            commit_pending <= 1'b0;
         end else if (commit_req) begin
            commit_pending <= 1'b1;
         end
         // A write landing on the commit edge stays dirty for the next commit.
         dirty <= (do_commit ? '0 : dirty) | reg_hit;
         for (int i = 0; i < NUM_REGS; i++)
            if (reg_hit[i])
               shadow[i] <= wr.register_data;
      end
   end

`ifdef CFG_READBACK_EN
   typedef enum logic {IDLE, SEND} rb_state_t;

   localparam int NUM_BYTES = REG_DATA_WIDTH / 8;
   localparam int BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

   rb_state_t                 rb_state;
   logic [REG_DATA_WIDTH-1:0] rb_word;
   logic [BYTE_W-1:0]         rb_byte;
   logic [REG_DATA_WIDTH-1:0] rb_sel;
   logic                      rb_idx_ok;
   logic                      rb_start;

   always_comb begin
      rb_sel    = '0;
      rb_idx_ok = 1'b0;
      for (int i = 0; i < NUM_REGS; i++)
         if (wr.register_data[REG_ADDR_WIDTH-1:0] == REG_ADDR_WIDTH'(i)) begin
            rb_sel    = active[i];
            rb_idx_ok = 1'b1;
         end
   end

   assign rdbk_err = rdbk_req && (!rb_idx_ok || rb_state == SEND);
   assign rb_start = rdbk_req && rb_idx_ok && rb_state == IDLE;

   // Bytes go out LSB first; each stays on tx_data until acknowledged.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rb_state <= IDLE;
         rb_word  <= '0;
         rb_byte  <= '0;
         tx_data  <= '0;
         tx_rdy   <= 1'b0;
      end else if (wr.rst_seq) begin
         rb_state <= IDLE;
         rb_byte  <= '0;
         tx_rdy   <= 1'b0;
      end else begin
         case (rb_state)
            IDLE: begin
               if (rb_start) begin
                  rb_word  <= rb_sel;
                  rb_byte  <= '0;
                  tx_data  <= rb_sel[7:0];
                  tx_rdy   <= 1'b1;
                  rb_state <= SEND;
               end
            end
            SEND: begin
               if (tx_ack) begin
                  if (rb_byte == BYTE_W'(NUM_BYTES - 1)) begin
                     tx_rdy   <= 1'b0;
                     rb_state <= IDLE;
                  end else begin
                     rb_byte <= rb_byte + 1'b1;
                     tx_data <= rb_word[(int'(rb_byte) + 1) * 8 +: 8];
                  end
               end
            end
            default: rb_state <= IDLE;
         endcase
      end
   end
`else
   assign rdbk_err = rdbk_req;
`endif

endmodule

// File: doc/configuration_register_bank.md
Name: configuration_register_bank

Overview:
Downstream consumer of the register-write stream produced by the host-link RX deframer (register_addr/register_data/register_rdy plus the rst_seq pulse). Holds NUM_REGS configuration registers in a shadow/active pair, so a batch of writes takes effect atomically on a commit command. Commits are deferred while the acquisition core reports busy. Exports the active registers as a flat bus to the acquisition, trigger and decimation blocks.

Parameters:
REG_ADDR_WIDTH, 8, width of register_addr
REG_DATA_WIDTH, 16, width of register_data and of each config register; multiple of 8
NUM_REGS, 8, number of config registers at addresses 0..NUM_REGS-1; NUM_REGS < 2**REG_ADDR_WIDTH - 2
COMMIT_ADDR, 8'hFF, write to this address commits shadow to active (data ignored)
RDBK_ADDR, 8'hFE, readback request address (only meaningful with CFG_READBACK_EN)
REG_DEFAULTS, 0, NUM_REGS*REG_DATA_WIDTH flat reset values; register i is bits [(i+1)*W-1:i*W]

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is asynchronous and active-low
register_addr  in  REG_ADDR_WIDTH  write address from RX deframer
register_data  in  REG_DATA_WIDTH  write data
register_rdy  in  1  one-cycle write strobe
rst_seq  in  1  one-cycle soft-reset strobe from RX deframer
hold  in  1  acquisition busy; commits are deferred while high
cfg_regs  out  NUM_REGS*REG_DATA_WIDTH  active registers, flat, register i at [(i+1)*W-1:i*W]
update_mask  out  NUM_REGS  one-cycle pulse; bit i set if register i changed value on the commit
commit_pending  out  1  a commit is waiting for hold to drop
cfg_rst  out  1  one-cycle pulse after a soft reset is applied
addr_err  out  1  one-cycle pulse on a write to an unmapped address
tx_data  out  8  readback byte (CFG_READBACK_EN only)
tx_rdy  out  1  readback byte valid (CFG_READBACK_EN only)
tx_ack  in  1  readback byte consumed (CFG_READBACK_EN only)

Behaviour:
- Async reset (rst low): shadow = active = REG_DEFAULTS; dirty = 0; update_mask, commit_pending, cfg_rst, addr_err = 0; readback FSM IDLE with tx_rdy = 0 and tx_data = 0.
- Write (register_rdy = 1), address < NUM_REGS: shadow[addr] <= data; dirty[addr] <= 1. The active copy is unchanged.
- Write to COMMIT_ADDR with hold = 0: on the next edge, active <= shadow for every register. update_mask <= dirty & (shadow != old active), bitwise per register. dirty <= 0. Result: cfg_regs changes exactly 1 cycle after the strobe.
- Write to COMMIT_ADDR with hold = 1: commit_pending <= 1. The commit executes on the first edge where hold = 0, using the shadow contents at that moment, so writes made meanwhile are included. Then commit_pending <= 0.
- Repeated commits while pending: merged into a single commit.
- Commit with no dirty registers: active is unchanged and update_mask = 0.
- Write to a shadow register in the same cycle a pending commit executes: the commit uses the old shadow value; the new write remains dirty.
- Any other address, or RDBK_ADDR without the macro: ignored, with addr_err pulsed for 1 cycle.
- rst_seq = 1: shadow = active = REG_DEFAULTS; dirty, commit_pending and readback are cleared; update_mask = 0; cfg_rst pulses the next cycle. rst_seq has priority over a simultaneous register_rdy, and that write is dropped.
- update_mask, cfg_rst and addr_err are always single-cycle pulses.

Optional Feature:
CFG_READBACK_EN
- Defined:
  - Write to RDBK_ADDR with register_data[REG_ADDR_WIDTH-1:0] = index < NUM_REGS: the FSM moves IDLE -> SEND and latches active[index].
  - SEND emits REG_DATA_WIDTH/8 bytes, LSB byte first, over tx_data/tx_rdy/tx_ack. tx_rdy is held high with tx_data stable until a cycle with tx_ack = 1; the next byte is presented the following cycle. After the last byte the FSM returns to IDLE.
  - Index >= NUM_REGS, or a request while in SEND: dropped with an addr_err pulse.
  - rst_seq during SEND aborts the transfer: tx_rdy = 0.
- Undefined: the tx ports and the FSM are absent, and RDBK_ADDR writes are treated as unmapped.

Test Plan:
1. Reset release -> cfg_regs = REG_DEFAULTS, all pulses 0. Then write addr 2 = 16'h1234 with no commit -> cfg_regs unchanged.
2. Write addr 2 = 16'h1234, addr 5 = 16'h00FF, then a COMMIT_ADDR write (hold 0) -> next cycle the regs hold 16'h1234 and 16'h00FF, update_mask = 8'b0010_0100 for 1 cycle.
3. hold = 1, commit -> commit_pending = 1 and cfg_regs unchanged. Write addr 3 = 16'hABCD. Drop hold -> addr 3 = 16'hABCD active, commit_pending = 0.
4. Write addr 8'h40 -> addr_err pulses 1 cycle, no state change. rst_seq together with register_rdy (addr 1) -> all registers = defaults, cfg_rst pulses 1 cycle, write lost.
5. Re-commit identical values -> update_mask = 0. Commit with nothing dirty -> update_mask = 0.
6. (CFG_READBACK_EN) Active reg 2 = 16'h1234, write RDBK_ADDR data 2, tx_ack delayed 3 cycles -> bytes 8'h34 then 8'h12, each held until tx_ack. A second request during SEND -> addr_err pulses.
